and_64x1: RTL and testbench

Registered 64-bit bitwise AND unit for the Y86 execute stage. It computes `out = a & b` from 64 single-bit AND slices and captures the result in an output register with one cycle of latency. A valid strobe travels alongside the data. Optional condition-code flags feed the ALU flag logic.

---
 rtl/y86_alu_pkg.sv | 11 +
 rtl/and_bit.sv | 10 +
 rtl/and_64x1.sv | 69 ++++++
 tb/tb_and_64x1.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU definitions: word width, word type and register reset values.
package y86_alu_pkg;

  localparam int WORD_W = 64;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t OUT_RST  = '0;
  localparam logic  FLAG_RST = 1'b0;

endpackage

// File: rtl/and_bit.sv
// One bit slice of the bitwise AND unit.
module and_bit (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = x & y;

endmodule

// File: rtl/and_64x1.sv
// Registered bitwise AND for the Y86 execute stage, one cycle of latency.
// Define AND64_FLAGS_EN to add the registered zero (zf) and sign (sf) flags.
module and_64x1
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef AND64_FLAGS_EN
  ,
  output logic             zf,
  output logic             sf
`endif
);

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and_bit u_bit (
      .x(a[i]),
      .y(b[i]),
      .z(w_res[i])
    );
  end

  // The result only loads on a valid strobe, so idle-cycle operands never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= OUT_RST[WIDTH-1:0];
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_res;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;

`ifdef AND64_FLAGS_EN
  logic r_zf;
  logic r_sf;

  // Flags reset low even though the reset result is zero; they describe the last capture only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= FLAG_RST;
      r_sf <= FLAG_RST;
    end else if (in_valid) begin
      r_zf <= (w_res == '0);
      r_sf <= w_res[WIDTH-1];
    end
  end

  assign zf = r_zf;
  assign sf = r_sf;
`endif

endmodule

// File: tb/tb_and_64x1.sv
// Self-checking bench for and_64x1: literal spot checks plus a per-cycle model comparison.
// Define AND64_FLAGS_EN to also check the zf/sf flags.
module tb_and_64x1;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] out;
  logic        outValid;
`ifdef AND64_FLAGS_EN
  logic        zf;
  logic        sf;
`endif

  int checkCount;
  int passCount;
  bit compareOn;

  logic [63:0] expOut;
  logic        expValid;
  logic        expZf;
  logic        expSf;

  and_64x1 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(inValid),
    .a(a),
    .b(b),
    .out(out),
    .out_valid(outValid)
`ifdef AND64_FLAGS_EN
    ,
    .zf(zf),
    .sf(sf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the last accepted pair's AND, and whether the previous cycle was valid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expOut   = 64'd0;
      expValid = 1'b0;
      expZf    = 1'b0;
      expSf    = 1'b0;
    end else begin
      expValid = inValid;
      if (inValid) begin
        expOut = a & b;
        expZf  = (expOut == 64'd0);
        expSf  = expOut[63];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s actual=0x%016h required=0x%016h", name, actual, required);
  endtask

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cycle_out", out, expOut);
      checkOutput("cycle_valid", {63'd0, outValid}, {63'd0, expValid});
`ifdef AND64_FLAGS_EN
      checkOutput("cycle_zf", {63'd0, zf}, {63'd0, expZf});
      checkOutput("cycle_sf", {63'd0, sf}, {63'd0, expSf});
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic [63:0] av, input logic [63:0] bv);
    inValid = v;
    a       = av;
    b       = bv;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] basicA [4];
  logic [63:0] basicB [4];
  logic [63:0] basicExp [4];
  int streamValidCount;

  initial begin
    checkCount = 0;
    passCount  = 0;
    compareOn  = 1'b0;
    basicA[0] = 64'd1092835;  basicB[0] = -64'sd1020; basicExp[0] = 64'h10AC00;
    basicA[1] = 64'b1011;     basicB[1] = 64'b1100;   basicExp[1] = 64'd8;
    basicA[2] = -64'sd2;      basicB[2] = 64'd13;     basicExp[2] = 64'd12;
    basicA[3] = -64'sd2;      basicB[3] = -64'sd13;   basicExp[3] = -64'sd14;

    rst_n = 1'b0;
    applyStimulus(1'b1, '1, '1);
    #2;
    compareOn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("reset_out", out, 64'd0);
      checkOutput("reset_valid", {63'd0, outValid}, 64'd0);
`ifdef AND64_FLAGS_EN
      checkOutput("reset_zf", {63'd0, zf}, 64'd0);
      checkOutput("reset_sf", {63'd0, sf}, 64'd0);
`endif
    end
    #2;
    rst_n = 1'b1;

    nextCycle();
    checkOutput("first_capture_valid", {63'd0, outValid}, 64'd1);
    checkOutput("first_capture_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, basicA[i], basicB[i]);
      nextCycle();
      checkOutput($sformatf("basic_%0d", i), out, basicExp[i]);
      checkOutput($sformatf("basic_valid_%0d", i), {63'd0, outValid}, 64'd1);
    end

`ifdef AND64_FLAGS_EN
    applyStimulus(1'b1, 64'b1011, 64'b0100);
    nextCycle();
    checkOutput("flag_zero_out", out, 64'd0);
    checkOutput("flag_zero_zf", {63'd0, zf}, 64'd1);
    checkOutput("flag_zero_sf", {63'd0, sf}, 64'd0);
    applyStimulus(1'b1, '1, '1);
    nextCycle();
    checkOutput("flag_neg_out", out, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("flag_neg_zf", {63'd0, zf}, 64'd0);
    checkOutput("flag_neg_sf", {63'd0, sf}, 64'd1);
`endif

    applyStimulus(1'b1, 64'b1001, 64'b1001);
    nextCycle();
    checkOutput("hold_load", out, 64'd9);
    applyStimulus(1'b0, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("hold_out", out, 64'd9);
      checkOutput("hold_valid", {63'd0, outValid}, 64'd0);
    end

    streamValidCount = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      nextCycle();
      if (outValid) streamValidCount++;
    end
    applyStimulus(1'b0, 64'd0, 64'd0);
    checkOutput("stream_valid_count", 64'(streamValidCount), 64'd12);

    applyStimulus(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out", out, 64'd0);
    checkOutput("midreset_valid", {63'd0, outValid}, 64'd0);
    applyStimulus(1'b1, 64'hF0F0, 64'h0FF0);
    nextCycle();
    checkOutput("midreset_hold_valid", {63'd0, outValid}, 64'd0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    checkOutput("post_reset_out", out, 64'h00F0);
    checkOutput("post_reset_valid", {63'd0, outValid}, 64'd1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom},
                    ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom});
      nextCycle();
    end
    applyStimulus(1'b0, 64'd0, 64'd0);
    nextCycle();
    @(negedge clk);
    compareOn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
